// File: rtl/cpu_defs.sv
// Shared definitions for the data-memory stage: funct3 access encodings, FSM states, memory width.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package cpu_defs;

   localparam int DMEM_AW_DEF = 12;

   // RV32I load encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // RV32I store encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // High when a memory op must be rejected: read and write together, an
   // encoding that does not exist for the direction, or a misaligned address.
   function automatic logic access_fault(input logic       rd,
                                         input logic       wr,
                                         input logic [2:0] f3,
                                         input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      if (rd && wr) begin
         bad = 1'b1;
      end else if (rd) begin
         case (f3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = lo[0];
            F3_LW:         bad = |lo;
            default:       bad = 1'b1;
         endcase
      end else if (wr) begin
         case (f3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = lo[0];
            F3_SW:   bad = |lo;
            default: bad = 1'b1;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and the data memory (slave).
// Latency: none, wires only; the master holds a request until mem_ack.
// Backpressure: memory stalls the master by withholding mem_ack.
// Signals: mem_req/mem_we/mem_addr(word)/mem_wdata/mem_be from master; mem_ack/mem_rdata from slave.
interface mem_stage_if #(
   parameter int AW = cpu_defs::DMEM_AW_DEF - 2
) ();

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ack;
   logic [31:0]   mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/mem_align.sv
// Byte-lane formatting: store replication + byte enables, load lane select + sign/zero extension.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct3/addr_lo select the access; st_data -> st_wdata/st_be; ld_word -> ld_data.
module mem_align
   import cpu_defs::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] st_data,
   input  logic [31:0] ld_word,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Stores: replicate the datum over every lane it could land in, so the
   // memory only has to honour st_be.
   always_comb begin
      st_wdata = st_data;
      st_be    = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            st_wdata = {4{st_data[7:0]}};
            st_be    = 4'b0001 << addr_lo;
         end
         2'b01: begin
            st_wdata = {2{st_data[15:0]}};
            st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = ld_word[{addr_lo, 3'b000} +: 8];
      ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
      ld_data = ld_word;
      case (funct3)
         F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
         F3_LBU:  ld_data = {24'd0, ld_byte};
         F3_LHU:  ld_data = {16'd0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline data-memory stage: issues loads/stores on the dmem bus, passes ALU results through.
// Latency: 1 cycle for pass-through and faults; ack cycle + 1 for memory ops (2 minimum).
// Backpressure: o_stall holds upstream from acceptance until the ack cycle; memory stalls via mem_ack.
// Ports: i_clk, i_rst (async, active-high); i_valid/i_mem_read/i_mem_write/i_funct3/i_addr/i_wdata in;
//        o_valid/o_result/o_fault/o_stall to write-back and upstream; dmem master modport to data memory.
module mem_stage
   import cpu_defs::*;
#(
   parameter int DMEM_AW = DMEM_AW_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   input  logic        i_mem_read,
   input  logic        i_mem_write,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_valid,
   output logic [31:0] o_result,
   output logic        o_fault,
   output logic        o_stall,
   mem_stage_if.master dmem
);

   state_t state, state_nxt;

   logic               is_mem;
   logic               fault;
   logic               accept;
   logic               done;

   logic [1:0]         lat_lo;
   logic [2:0]         lat_f3;
   logic               lat_we;

   logic               req_q;
   logic               we_q;
   logic [DMEM_AW-3:0] addr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;

   logic [2:0]         al_f3;
   logic [1:0]         al_lo;
   logic [31:0]        al_wdata;
   logic [3:0]         al_be;
   logic [31:0]        al_ldata;

   assign is_mem = i_mem_read | i_mem_write;
   assign fault  = access_fault(i_mem_read, i_mem_write, i_funct3, i_addr[1:0]);

   // The aligner formats the incoming store while idle and extracts the
   // returning load (with the latched access shape) while waiting.
   assign al_f3 = (state == ST_IDLE) ? i_funct3    : lat_f3;
   assign al_lo = (state == ST_IDLE) ? i_addr[1:0] : lat_lo;

   mem_align u_align (
      .funct3   (al_f3),
      .addr_lo  (al_lo),
      .st_data  (i_wdata),
      .ld_word  (dmem.mem_rdata),
      .st_wdata (al_wdata),
      .st_be    (al_be),
      .ld_data  (al_ldata)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_valid && is_mem && !fault) begin
               accept    = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmem.mem_ack) begin
               done      = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // RESP is not stalled: upstream still shows the finished op and advances
   // past it at the end of this cycle.
   assign o_stall = accept || (state == ST_WAIT);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_valid  <= 1'b0;
         o_fault  <= 1'b0;
         o_result <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         lat_lo   <= '0;
         lat_f3   <= '0;
         lat_we   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_fault <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_valid  <= i_valid && (!is_mem || fault);
               o_fault  <= i_valid && is_mem && fault;
               o_result <= (i_valid && !is_mem) ? i_addr : '0;
               if (accept) begin
                  req_q   <= 1'b1;
                  we_q    <= i_mem_write;
                  addr_q  <= i_addr[DMEM_AW-1:2];
                  wdata_q <= al_wdata;
                  be_q    <= al_be;
                  lat_lo  <= i_addr[1:0];
                  lat_f3  <= i_funct3;
                  lat_we  <= i_mem_write;
               end
            end
            ST_WAIT: begin
               if (done) begin
                  req_q    <= 1'b0;
                  we_q     <= 1'b0;
                  be_q     <= '0;
                  o_valid  <= 1'b1;
                  o_result <= lat_we ? '0 : al_ldata;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem.mem_req   = req_q;
   assign dmem.mem_we    = we_q;
   assign dmem.mem_addr  = addr_q;
   assign dmem.mem_wdata = wdata_q;
   assign dmem.mem_be    = be_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed vector table, multi-cycle sequences, randomized ops vs. a byte-memory model.
// Latency: n/a.
// Backpressure: the bench plays the data memory, acking after a chosen number of request cycles.
module tb_mem_stage;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        i_mem_read;
   logic        i_mem_write;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_valid;
   logic [31:0] o_result;
   logic        o_fault;
   logic        o_stall;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;

   always #5 i_clk = ~i_clk;

   mem_stage_if #(.AW(10)) dmem ();
   assign dmem.mem_ack   = i_mem_ack;
   assign dmem.mem_rdata = i_mem_rdata;

   mem_stage #(.DMEM_AW(12)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_mem_read  (i_mem_read),
      .i_mem_write (i_mem_write),
      .i_funct3    (i_funct3),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .o_valid     (o_valid),
      .o_result    (o_result),
      .o_fault     (o_fault),
      .o_stall     (o_stall),
      .dmem        (dmem)
   );

   int total = 0;
   int bad   = 0;

   // Data memory as the DUT sees it (words) and the model's view (bytes).
   logic [31:0] wmem [0:1023];
   logic [7:0]  bmem [0:4095];

   // Observations from the most recent run_op
   logic        r_valid, r_fault, r_stall0, r_stall_ok, r_stable, r_valid_after, r_timeout, r_we;
   logic [31:0] r_result, r_mwdata;
   logic [3:0]  r_be;
   logic [9:0]  r_maddr;
   int          r_req_cycles;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
      logic        exp_fault;
      logic [31:0] exp_result;
      logic        exp_req;
      logic [9:0]  exp_maddr;
      logic [3:0]  exp_be;
      logic [31:0] exp_mwdata;
   } vec_t;

   vec_t vt[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reads a load of the given shape out of the byte-level model memory.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
      int          sz;
      int          ba;
      logic [31:0] val;
      sz  = 1 << f3[1:0];
      ba  = int'(addr % 4096);
      val = '0;
      for (int k = 0; k < sz; k++) val = val | ({24'd0, bmem[ba + k]} << (8 * k));
      if (!f3[2] && sz < 4 && val[8 * sz - 1]) val = val | ~((32'h1 << (8 * sz)) - 1);
      return val;
   endfunction

   // Presents one op, plays memory (ack after lat request cycles), records what the DUT did.
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                         input logic use_mem, input logic [31:0] rdata);
      int cyc;
      r_valid = 0; r_fault = 0; r_result = 'x; r_req_cycles = 0;
      r_stall_ok = 1; r_stable = 1; r_timeout = 0; r_we = 0;
      r_be = '0; r_mwdata = '0; r_maddr = '0;
      @(negedge i_clk);
      i_valid = 1; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3;
      i_addr = addr; i_wdata = wdata; i_mem_ack = 0;
      #1 r_stall0 = o_stall;
      @(negedge i_clk);
      if (!dmem.mem_req) begin
         r_valid = o_valid; r_fault = o_fault; r_result = o_result;
         if (o_stall) r_stall_ok = 0;
         i_valid = 0; i_mem_read = 0; i_mem_write = 0;
      end else begin
         r_be = dmem.mem_be; r_mwdata = dmem.mem_wdata; r_maddr = dmem.mem_addr; r_we = dmem.mem_we;
         cyc = 1;
         while (dmem.mem_req && cyc <= 20) begin
            r_req_cycles++;
            if (!o_stall || o_valid) r_stall_ok = 0;
            if (dmem.mem_addr !== r_maddr || dmem.mem_be !== r_be ||
                dmem.mem_wdata !== r_mwdata || dmem.mem_we !== r_we) r_stable = 0;
            if (cyc == lat) begin
               i_mem_ack   = 1;
               i_mem_rdata = use_mem ? wmem[dmem.mem_addr] : rdata;
               if (use_mem && dmem.mem_we)
                  for (int b = 0; b < 4; b++)
                     if (dmem.mem_be[b]) wmem[dmem.mem_addr][8*b +: 8] = dmem.mem_wdata[8*b +: 8];
            end else begin
               i_mem_ack   = 0;
               i_mem_rdata = $urandom;
            end
            @(negedge i_clk);
            cyc++;
         end
         if (cyc > 20) r_timeout = 1;
         i_mem_ack = 0;
         r_valid = o_valid; r_fault = o_fault; r_result = o_result;
         if (o_stall) r_stall_ok = 0;
         i_valid = 0; i_mem_read = 0; i_mem_write = 0;
      end
      @(negedge i_clk);
      r_valid_after = o_valid;
   endtask

   logic [31:0] bb [0:2];
   logic [2:0]  lf [0:4];

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin : main
      vec_t        v;
      logic        stall_seen, vflag, rd, wr, ereq, efault, legal, lanes_ok;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, eres, tmp;
      logic [3:0]  ebe;
      int          kind, lat, sz, ba, off;

      for (int w = 0; w < 1024; w++) begin
         wmem[w] = $urandom;
         for (int k = 0; k < 4; k++) bmem[4*w + k] = wmem[w][8*k +: 8];
      end
      bb[0] = 32'h11; bb[1] = 32'h22; bb[2] = 32'h33;
      lf[0] = 3'b000; lf[1] = 3'b001; lf[2] = 3'b010; lf[3] = 3'b100; lf[4] = 3'b101;

      // ---------------- reset state ----------------
      i_rst = 1; i_valid = 0; i_mem_read = 0; i_mem_write = 0; i_funct3 = 0;
      i_addr = 0; i_wdata = 0; i_mem_ack = 0; i_mem_rdata = 0;
      #1;
      check("reset_ctrl", {27'd0, o_valid, o_fault, o_stall, dmem.mem_req, dmem.mem_we}, 32'd0);
      check("reset_be", {28'd0, dmem.mem_be}, 32'd0);
      check("reset_result", o_result, 32'd0);
      check("reset_wdata", dmem.mem_wdata, 32'd0);
      check("reset_addr", {22'd0, dmem.mem_addr}, 32'd0);
      @(negedge i_clk); @(negedge i_clk);
      i_rst = 0;

      // ---------------- directed vector table ----------------
      //            rd    wr    f3      addr          wdata         lat rdata         flt  result        req  maddr   be       mwdata
      vt.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 3, 32'h0,        1'b0, 32'h0,        1'b1, 10'h004, 4'b1111, 32'hDEADBEEF});
      vt.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 1, 32'h0,       1'b0, 32'h0,        1'b1, 10'h004, 4'b1000, 32'hA5A5A5A5});
      vt.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0021, 32'h0,        2, 32'h0000_8000, 1'b0, 32'hFFFFFF80, 1'b1, 10'h008, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0021, 32'h0,        1, 32'h0000_8000, 1'b0, 32'h00000080, 1'b1, 10'h008, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h0,        1, 32'h8001_0000, 1'b0, 32'hFFFF8001, 1'b1, 10'h008, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0022, 32'h0,        2, 32'h8001_0000, 1'b0, 32'h00008001, 1'b1, 10'h008, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_001C, 32'h0,        1, 32'h1234_5678, 1'b0, 32'h12345678, 1'b1, 10'h007, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_00FF, 32'h0,        4, 32'h7F00_0000, 1'b0, 32'h0000007F, 1'b1, 10'h03F, 4'b0000, 32'h0});
      vt.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h1234_ABCD, 2, 32'h0,       1'b0, 32'h0,        1'b1, 10'h004, 4'b1100, 32'hABCDABCD});
      vt.push_back('{1'b0, 1'b1, 3'b010, 32'hABCD_E3F8, 32'hCAFE_F00D, 1, 32'h0,       1'b0, 32'h0,        1'b1, 10'h0FE, 4'b1111, 32'hCAFEF00D});
      vt.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0012, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0});
      vt.push_back('{1'b0, 1'b1, 3'b100, 32'h0000_0010, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0});
      vt.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0011, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0});
      vt.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0023, 32'h0,        1, 32'h0,        1'b1, 32'h0,        1'b0, 10'h000, 4'b0000, 32'h0});
      vt.push_back('{1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'h0,        1, 32'h0,        1'b0, 32'h12345678, 1'b0, 10'h000, 4'b0000, 32'h0});

      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         run_op(v.rd, v.wr, v.f3, v.addr, v.wdata, v.lat, 1'b0, v.rdata);
         check("vec_valid", {31'd0, r_valid}, 32'd1);
         check("vec_fault", {31'd0, r_fault}, {31'd0, v.exp_fault});
         check("vec_result", r_result, v.exp_result);
         check("vec_stall_accept", {31'd0, r_stall0}, {31'd0, v.exp_req});
         check("vec_req_cycles", r_req_cycles, v.exp_req ? v.lat : 0);
         check("vec_stall_shape", {31'd0, r_stall_ok}, 32'd1);
         check("vec_valid_one_cycle", {31'd0, r_valid_after}, 32'd0);
         check("vec_timeout", {31'd0, r_timeout}, 32'd0);
         if (v.exp_req) begin
            check("vec_maddr", {22'd0, r_maddr}, {22'd0, v.exp_maddr});
            check("vec_req_stable", {31'd0, r_stable}, 32'd1);
            check("vec_we", {31'd0, r_we}, {31'd0, v.wr});
            if (v.wr) begin
               check("vec_be", {28'd0, r_be}, {28'd0, v.exp_be});
               check("vec_mwdata", r_mwdata, v.exp_mwdata);
            end
         end
      end

      // ---------------- back-to-back pass-through ----------------
      stall_seen = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         if (i > 0) begin
            check("b2b_valid", {31'd0, o_valid}, 32'd1);
            check("b2b_result", o_result, bb[i-1]);
         end
         if (i < 3) begin
            i_valid = 1; i_mem_read = 0; i_mem_write = 0; i_addr = bb[i];
         end else begin
            i_valid = 0;
         end
         #1 if (o_stall) stall_seen = 1;
      end
      check("b2b_stall", {31'd0, stall_seen}, 32'd0);

      // ---------------- stray ack while idle is ignored ----------------
      @(negedge i_clk);
      i_mem_ack = 1;
      @(negedge i_clk);
      check("idle_ack_valid", {31'd0, o_valid}, 32'd0);
      check("idle_ack_req", {31'd0, dmem.mem_req}, 32'd0);
      i_mem_ack = 0;

      // ---------------- reset during WAIT ----------------
      @(negedge i_clk);
      i_valid = 1; i_mem_read = 1; i_mem_write = 0; i_funct3 = 3'b010; i_addr = 32'h40;
      @(negedge i_clk);
      check("rstwait_req_before", {31'd0, dmem.mem_req}, 32'd1);
      @(negedge i_clk);
      #2 i_rst = 1;
      #1;
      check("rstwait_req_drop", {31'd0, dmem.mem_req}, 32'd0);
      check("rstwait_be_drop", {28'd0, dmem.mem_be}, 32'd0);
      i_valid = 0; i_mem_read = 0;
      @(negedge i_clk);
      i_rst = 0;
      vflag = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         if (o_valid || dmem.mem_req) vflag = 1;
      end
      check("rstwait_no_valid", {31'd0, vflag}, 32'd0);
      run_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 2, 1'b1, 32'h0);
      check("rstwait_next_valid", {31'd0, r_valid}, 32'd1);
      check("rstwait_next_result", r_result, model_load(3'b010, 32'h40));
      check("rstwait_next_req_cycles", r_req_cycles, 2);

      // ---------------- randomized ops vs. byte-memory model ----------------
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 3);
         rd = 0; wr = 0; f3 = 3'($urandom_range(0, 7));
         case (kind)
            1: begin rd = 1; f3 = lf[$urandom_range(0, 4)]; end
            2: begin wr = 1; f3 = 3'($urandom_range(0, 2)); end
            3: begin rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1)); end
            default: ;
         endcase
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[11:6] = '0;
         sz = 1 << f3[1:0];
         if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
         wdata = $urandom;
         lat   = $urandom_range(1, 4);

         efault = 0; ereq = 0; eres = 32'd0; ebe = 4'd0;
         ba  = int'(addr % 4096);
         off = ba % 4;
         if (!(rd || wr)) begin
            eres = addr;
         end else begin
            legal = !(rd && wr) &&
                    (rd ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                        : (f3 inside {3'b000, 3'b001, 3'b010}));
            if (legal && (ba % sz) != 0) legal = 0;
            if (!legal) begin
               efault = 1;
            end else begin
               ereq = 1;
               if (rd) begin
                  eres = model_load(f3, addr);
               end else begin
                  ebe = 4'(((1 << sz) - 1) << off);
               end
            end
         end

         run_op(rd, wr, f3, addr, wdata, lat, 1'b1, 32'h0);

         check("rnd_valid", {31'd0, r_valid}, 32'd1);
         check("rnd_fault", {31'd0, r_fault}, {31'd0, efault});
         check("rnd_result", r_result, eres);
         check("rnd_stall_accept", {31'd0, r_stall0}, {31'd0, ereq});
         check("rnd_req_cycles", r_req_cycles, ereq ? lat : 0);
         check("rnd_stall_shape", {31'd0, r_stall_ok}, 32'd1);
         check("rnd_valid_one_cycle", {31'd0, r_valid_after}, 32'd0);
         check("rnd_timeout", {31'd0, r_timeout}, 32'd0);
         if (ereq) begin
            check("rnd_maddr", {22'd0, r_maddr}, 32'(ba / 4));
            check("rnd_req_stable", {31'd0, r_stable}, 32'd1);
            if (wr) begin
               check("rnd_be", {28'd0, r_be}, {28'd0, ebe});
               lanes_ok = 1;
               for (int l = 0; l < 4; l++) begin
                  if (ebe[l]) begin
                     tmp = wdata >> (8 * (l - off));
                     if (r_mwdata[8*l +: 8] !== tmp[7:0]) lanes_ok = 0;
                  end
               end
               check("rnd_store_lanes", {31'd0, lanes_ok}, 32'd1);
               for (int k = 0; k < sz; k++) begin
                  tmp = wdata >> (8 * k);
                  bmem[ba + k] = tmp[7:0];
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
